// File: rtl/uart_fifo_bridge_pkg.sv
// Shared MMIO map, region code and status bit positions for the UART FIFO bridge.
package uart_fifo_bridge_pkg;

    localparam logic [3:0] MMIO_REGION    = 4'h8;

    localparam logic [7:0] MMIO_STATUS    = 8'h00;
    localparam logic [7:0] MMIO_RX_DATA   = 8'h04;
    localparam logic [7:0] MMIO_TX_DATA   = 8'h08;
    localparam logic [7:0] MMIO_CYCLE_CNT = 8'h10;
    localparam logic [7:0] MMIO_INST_CNT  = 8'h14;
    localparam logic [7:0] MMIO_CNT_RST   = 8'h18;

    localparam int STAT_TX_NOT_FULL  = 0;
    localparam int STAT_RX_NOT_EMPTY = 1;
    localparam int STAT_TX_OVF       = 2;

endpackage

// File: rtl/uart_fifo_bridge_sync_fifo.sv
// First-word-fall-through synchronous FIFO; full/empty come from the pre-cycle count,
// so a push into a full FIFO is refused even when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    // Head is forced to zero while empty so the output is defined straight out of reset.
    assign dout_o  = empty_o ? '0 : mem_q[rptr_q];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + PTR_ONE;
        if (do_pop)  rptr_d = rptr_q + PTR_ONE;
        if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
        else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/uart_fifo_bridge.sv
// MMIO bridge between the CPU execute stage and the UART: TX/RX FIFOs, status, perf counters.
// Counters are built only when UART_FIFO_BRIDGE_COUNTERS_EN is defined.
module uart_fifo_bridge
    import uart_fifo_bridge_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mmio_addr,
    input  logic [31:0] mmio_wdata,
    input  logic        mmio_we,
    input  logic        mmio_re,
    output logic [31:0] mmio_rdata,
    input  logic        inst_retire,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);
    localparam int CW = $clog2(DEPTH) + 1;

    // UART handshakes: a byte moves on a rising clk edge where valid && ready are both high;
    // valid never waits on ready, and data is stable while valid is high.
    logic          sel;
    logic [7:0]    off;
    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]    rx_dout;
    logic [CW-1:0] tx_count, rx_count;
    logic          status_rd, cnt_clr;
    logic          ovf_q, ovf_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   status_val, cyc_val, inst_val;

    assign sel       = (mmio_addr[31:28] == MMIO_REGION);
    assign off       = mmio_addr[7:0];
    assign tx_push   = sel && mmio_we && (off == MMIO_TX_DATA);
    assign status_rd = sel && mmio_re && (off == MMIO_STATUS);
    assign rx_pop    = sel && mmio_re && (off == MMIO_RX_DATA);
    assign cnt_clr   = sel && mmio_we && (off == MMIO_CNT_RST);
    assign tx_pop    = uart_tx_valid && uart_tx_ready;
    assign rx_push   = uart_rx_valid && uart_rx_ready;

    assign uart_tx_valid = !tx_empty;
    assign uart_rx_ready = !rx_full;
    assign mmio_rdata    = rdata_q;

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_push),
        .din_i   (mmio_wdata[7:0]),
        .pop_i   (tx_pop),
        .dout_o  (uart_tx_data),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_push),
        .din_i   (uart_rx_data),
        .pop_i   (rx_pop),
        .dout_o  (rx_dout),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    always_comb begin
        status_val = '0;
        status_val[STAT_TX_NOT_FULL]  = !tx_full;
        status_val[STAT_RX_NOT_EMPTY] = !rx_empty;
        status_val[STAT_TX_OVF]       = ovf_q;
    end

    // A new overflow in the same cycle as a status read survives the clear.
    always_comb begin
        ovf_d = ovf_q;
        if (status_rd)          ovf_d = 1'b0;
        if (tx_push && tx_full) ovf_d = 1'b1;
    end

`ifdef UART_FIFO_BRIDGE_COUNTERS_EN
    logic [31:0] cyc_q, inst_q;

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cyc_q  <= '0;
            inst_q <= '0;
        end else begin
            cyc_q  <= cyc_q + 32'd1;
            if (inst_retire) inst_q <= inst_q + 32'd1;
        end
    end

    assign cyc_val  = cyc_q;
    assign inst_val = inst_q;

    logic unused_bits;
    assign unused_bits = ^{mmio_addr[27:8], mmio_wdata[31:8], tx_count, rx_count};
`else
    assign cyc_val  = '0;
    assign inst_val = '0;

    logic unused_bits;
    assign unused_bits = ^{mmio_addr[27:8], mmio_wdata[31:8], tx_count, rx_count,
                           inst_retire, cnt_clr};
`endif

    // Every read strobe reloads the data register; unselected or unmapped reads load zero.
    always_comb begin
        rdata_d = rdata_q;
        if (mmio_re) begin
            rdata_d = '0;
            if (sel) begin
                case (off)
                    MMIO_STATUS:    rdata_d = status_val;
                    MMIO_RX_DATA:   rdata_d = {24'b0, rx_dout};
                    MMIO_CYCLE_CNT: rdata_d = cyc_val;
                    MMIO_INST_CNT:  rdata_d = inst_val;
                    default:        rdata_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Self-checking bench for uart_fifo_bridge: decode table, TX/RX FIFO sequences,
// counters (expectations follow UART_FIFO_BRIDGE_COUNTERS_EN) and reset mid-transfer.
module tb_uart_fifo_bridge;

    localparam int DEPTH = 8;
    localparam logic [31:0] A_STATUS = 32'h8000_0000;
    localparam logic [31:0] A_RX     = 32'h8000_0004;
    localparam logic [31:0] A_TX     = 32'h8000_0008;
    localparam logic [31:0] A_CYC    = 32'h8000_0010;
    localparam logic [31:0] A_INST   = 32'h8000_0014;
    localparam logic [31:0] A_CLR    = 32'h8000_0018;
`ifdef UART_FIFO_BRIDGE_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk, rst;
    logic [31:0] mmio_addr, mmio_wdata, mmio_rdata;
    logic        mmio_we, mmio_re, inst_retire;
    logic [7:0]  uart_tx_data, uart_rx_data;
    logic        uart_tx_valid, uart_tx_ready, uart_rx_valid, uart_rx_ready;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];

    uart_fifo_bridge #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .mmio_addr     (mmio_addr),
        .mmio_wdata    (mmio_wdata),
        .mmio_we       (mmio_we),
        .mmio_re       (mmio_re),
        .mmio_rdata    (mmio_rdata),
        .inst_retire   (inst_retire),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        mmio_addr  = addr;
        mmio_wdata = data;
        mmio_we    = 1'b1;
        @(negedge clk);
        mmio_we    = 1'b0;
        mmio_addr  = '0;
        mmio_wdata = '0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        mmio_addr = addr;
        mmio_re   = 1'b1;
        @(negedge clk);
        mmio_re   = 1'b0;
        mmio_addr = '0;
        check(name, mmio_rdata, exp_q.pop_front());
    endtask

    task automatic tx_write(input logic [7:0] b);
        if (tx_q.size() < DEPTH) tx_q.push_back(b);
        do_write(A_TX, {24'h0, b});
    endtask

    task automatic rx_send(input logic [7:0] b);
        if (rx_q.size() < DEPTH) rx_q.push_back(b);
        uart_rx_data  = b;
        uart_rx_valid = 1'b1;
        @(negedge clk);
        uart_rx_valid = 1'b0;
    endtask

    task automatic rx_read(input string name);
        logic [7:0] e;
        e = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
        do_read(A_RX, {24'h0, e}, name);
    endtask

    task automatic tx_drain();
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH && uart_tx_valid; i++) @(negedge clk);
        uart_tx_ready = 1'b0;
        check("tx_drained_valid", {31'h0, uart_tx_valid}, 32'h0);
        check("tx_drained_model", tx_q.size(), 32'h0);
    endtask

    // TX monitor: checks each byte as it leaves, settled a little after the falling edge.
    always @(negedge clk) begin
        #1;
        if (!rst && uart_tx_valid && uart_tx_ready) begin
            if (tx_q.size() == 0) check("tx_unexpected_byte", {24'h0, uart_tx_data}, 32'hFFFF_FFFF);
            else                  check("tx_byte", {24'h0, uart_tx_data}, {24'h0, tx_q.pop_front()});
        end
    end

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[9];
    bit   retire_pat[100];
    int   n_retire;

    initial begin
        rst = 1'b1;
        mmio_addr = '0; mmio_wdata = '0; mmio_we = 1'b0; mmio_re = 1'b0;
        inst_retire = 1'b0; uart_tx_ready = 1'b0; uart_rx_data = '0; uart_rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_rdata", mmio_rdata, 32'h0);
        check("rst_tx_valid", {31'h0, uart_tx_valid}, 32'h0);
        check("rst_rx_ready", {31'h0, uart_rx_ready}, 32'h1);
        check("rst_tx_data", {24'h0, uart_tx_data}, 32'h0);

        vecs[0] = '{1'b0, 1'b1, A_STATUS,      32'h0,  32'h1, "tbl_status_reset"};
        vecs[1] = '{1'b0, 1'b1, A_RX,          32'h0,  32'h0, "tbl_rx_empty"};
        vecs[2] = '{1'b0, 1'b1, 32'h8000_000C, 32'h0,  32'h0, "tbl_unmapped_0c"};
        vecs[3] = '{1'b0, 1'b1, 32'h8000_0020, 32'h0,  32'h0, "tbl_unmapped_20"};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0008, 32'h77, 32'h0, "tbl_wr_unselected"};
        vecs[5] = '{1'b1, 1'b0, 32'h8000_000C, 32'h55, 32'h0, "tbl_wr_unmapped"};
        vecs[6] = '{1'b0, 1'b1, A_STATUS,      32'h0,  32'h1, "tbl_status_after_ignored"};
        vecs[7] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0,  32'h0, "tbl_rd_unselected"};
        vecs[8] = '{1'b0, 1'b1, 32'h9000_0000, 32'h0,  32'h0, "tbl_rd_region9"};
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].re) do_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
            else            do_write(vecs[i].addr, vecs[i].wdata);
        end
        check("tbl_tx_valid_idle", {31'h0, uart_tx_valid}, 32'h0);

        // TX ordering and handshake
        tx_write(8'h41);
        tx_write(8'h42);
        check("tx_valid_held", {31'h0, uart_tx_valid}, 32'h1);
        check("tx_head", {24'h0, uart_tx_data}, 32'h41);
        uart_tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        uart_tx_ready = 1'b0;
        check("tx_valid_after_two", {31'h0, uart_tx_valid}, 32'h0);
        check("tx_model_empty", tx_q.size(), 32'h0);

        // TX overflow: 9th byte dropped, sticky flag cleared by status read
        for (int i = 0; i < DEPTH + 1; i++) tx_write(8'($urandom_range(0, 255)));
        do_read(A_STATUS, 32'h4, "ovf_status");
        do_read(A_STATUS, 32'h0, "ovf_cleared");
        tx_drain();

        // RX single byte
        rx_send(8'h5A);
        do_read(A_STATUS, 32'h3, "rx_status_nonempty");
        rx_read("rx_5a");
        do_read(A_STATUS, 32'h1, "rx_status_empty");
        rx_read("rx_empty_read");

        // RX full: pop frees a slot next cycle, concurrent push is refused
        for (int i = 0; i < DEPTH; i++) rx_send(8'($urandom_range(0, 255)));
        check("rx_ready_full", {31'h0, uart_rx_ready}, 32'h0);
        uart_rx_data  = 8'hEE;
        uart_rx_valid = 1'b1;
        rx_read("rx_pop_while_full");
        uart_rx_valid = 1'b0;
        check("rx_ready_after_pop", {31'h0, uart_rx_ready}, 32'h1);
        for (int i = 0; i < DEPTH - 1; i++) rx_read("rx_drain");
        rx_read("rx_refused_not_stored");

        // Counters: 100 cycles after a clear, 40 of them retiring
        for (int i = 0; i < 100; i++) retire_pat[i] = (i < 40);
        for (int i = 99; i > 0; i--) begin
            int j;
            bit t;
            j = $urandom_range(0, i);
            t = retire_pat[i]; retire_pat[i] = retire_pat[j]; retire_pat[j] = t;
        end
        n_retire = 0;
        do_write(A_CLR, 32'h0);
        for (int i = 0; i < 100; i++) begin
            inst_retire = retire_pat[i];
            if (retire_pat[i]) n_retire++;
            @(negedge clk);
        end
        inst_retire = 1'b0;
        do_read(A_CYC,  CNT_EN ? 32'd100 : 32'd0, "cnt_cycles");
        do_read(A_INST, CNT_EN ? 32'(n_retire) : 32'd0, "cnt_insts");
        do_write(A_CLR, 32'h0);
        do_read(A_CYC,  32'd0, "cnt_cycles_cleared");
        do_read(A_INST, 32'd0, "cnt_insts_cleared");

        // Reset with bytes pending in TX
        for (int i = 0; i < 3; i++) tx_write(8'(8'h60 + i));
        check("pre_rst_tx_valid", {31'h0, uart_tx_valid}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tx_q.delete();
        check("post_rst_tx_valid", {31'h0, uart_tx_valid}, 32'h0);
        check("post_rst_tx_data", {24'h0, uart_tx_data}, 32'h0);
        check("post_rst_rx_ready", {31'h0, uart_rx_ready}, 32'h1);
        do_read(A_CYC,  32'd0, "post_rst_cycles");
        do_read(A_INST, 32'd0, "post_rst_insts");
        do_read(A_STATUS, 32'h1, "post_rst_status");

        check("scoreboard_empty", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
